// File: rtl/noc_sim_sequencer_pkg.sv
// Shared definitions for the NoC simulation sequencer.
//  - router command op encodings and command-bus widths
//  - credit-delay field placement inside the Init payload
//  - sequencer state encoding (exposed on the debug port)
// Routing entries on rt_data are forwarded to the routers unchanged, so the
// sequencer needs no knowledge of the destination / output-port fields.
package noc_sim_sequencer_pkg;

  localparam int OP_W     = 3;   // width of the router op field
  localparam int DATA_W   = 32;  // width of the command payload
  localparam int CREDIT_W = 12;  // credit delay occupies the low bits of Init data

  localparam logic [OP_W-1:0] OP_NOP          = 3'd0;
  localparam logic [OP_W-1:0] OP_LOAD_STAGING = 3'd1;
  localparam logic [OP_W-1:0] OP_PHASE0       = 3'd2;
  localparam logic [OP_W-1:0] OP_PHASE1       = 3'd3;
  localparam logic [OP_W-1:0] OP_LOAD_RT      = 3'd4;
  localparam logic [OP_W-1:0] OP_INIT         = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_LOAD_RT = 3'd2,
    ST_LD_STG  = 3'd3,
    ST_PH0     = 3'd4,
    ST_PH1     = 3'd5
  } seq_state_t;

  // Init payload: credit delay zero-extended into the data word.
  function automatic logic [DATA_W-1:0] init_data(input logic [CREDIT_W-1:0] credit);
    return {{(DATA_W-CREDIT_W){1'b0}}, credit};
  endfunction

endpackage

// File: rtl/noc_sim_sequencer_if.sv
// Router command bus plus routing-table load stream.
//  master : the sequencer (drives op/data/in_cycle and rt_ready)
//  slave  : routers / routing-table source (drive rt_valid/rt_data/rt_last)
//
// Handshake: a routing entry transfers on a rising clock edge where
// rt_valid and rt_ready are both high. rt_data and rt_last are meaningful
// only while rt_valid is high; a source holding rt_valid keeps rt_data and
// rt_last stable until the transfer. rt_ready may drop without a transfer.
// op/data/in_cycle are a broadcast with no back-pressure: every router
// consumes the command on the negedge following the posedge that drove it.
interface noc_sim_sequencer_if #(
  parameter int CYC_W = 16
);
  import noc_sim_sequencer_pkg::*;

  logic              rt_valid;
  logic [DATA_W-1:0] rt_data;
  logic              rt_last;
  logic              rt_ready;
  logic [OP_W-1:0]   op;
  logic [DATA_W-1:0] data;
  logic [CYC_W-1:0]  in_cycle;

  modport master (
    input  rt_valid, rt_data, rt_last,
    output rt_ready, op, data, in_cycle
  );

  modport slave (
    output rt_valid, rt_data, rt_last,
    input  rt_ready, op, data, in_cycle
  );

endinterface

// File: rtl/noc_seq_quiet_det.sv
// Quiescence detector.
//  clk, rst_n     clock / async active-low reset
//  done_vec       per-router done flags
//  inj_busy       external injector still has traffic
//  sample         strobe: commit this cycle's quiet decision to the counter
//  clear          zero the counter (start of a run)
//  cfg_quiet      consecutive quiet iterations required (0 behaves as 1)
//  quiet_reached  the counter value that 'sample' would store meets the
//                 threshold; valid in the same cycle as the strobe
module noc_seq_quiet_det #(
  parameter int NUM_ROUTERS = 16,
  parameter int QUIET_W     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_ROUTERS-1:0] done_vec,
  input  logic                   inj_busy,
  input  logic                   sample,
  input  logic                   clear,
  input  logic [QUIET_W-1:0]     cfg_quiet,
  output logic                   quiet_reached
);

  logic [QUIET_W-1:0] quiet_cnt_q;
  logic [QUIET_W-1:0] quiet_cnt_n;
  logic [QUIET_W-1:0] threshold;
  logic               quiet_now;

  assign quiet_now = (&done_vec) & ~inj_busy;
  assign threshold = (cfg_quiet == '0) ? QUIET_W'(1) : cfg_quiet;

  // Saturate rather than wrap so a long quiet stretch never looks short.
  always_comb begin
    quiet_cnt_n = '0;
    if (quiet_now) begin
      quiet_cnt_n = (&quiet_cnt_q) ? quiet_cnt_q : quiet_cnt_q + 1'b1;
    end
  end

  assign quiet_reached = (quiet_cnt_n >= threshold);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quiet_cnt_q <= '0;
    end else if (clear) begin
      quiet_cnt_q <= '0;
    end else if (sample) begin
      quiet_cnt_q <= quiet_cnt_n;
    end
  end

endmodule

// File: rtl/noc_sim_sequencer.sv
// Global cycle sequencer for the NoC simulation fabric.
// A run is: Init (credit delay) -> routing-table load -> repeated simulated
// cycles of LoadStaging / Phase0 / Phase1 until the network is quiet for
// cfg_quiet iterations, the cycle limit is hit, or abort.
//  clk, rst_n       clock / async active-low reset
//  start, abort     run control (start ignored while busy; abort ignored idle)
//  cfg_credit_dly   credit delay sent with Init
//  cfg_max_cycles   last simulated cycle allowed; 0 = unlimited
//  cfg_quiet        consecutive quiet iterations needed to finish
//  bus              command bus + routing-table stream (master side)
//  inj_busy         injector still has flits
//  done_vec         per-router done
//  busy             run in progress
//  finished         sticky: run ended normally or on the cycle limit
//  timeout          sticky: run ended on the cycle limit
//  state_dbg        current sequencer state
// All outputs are registered and represent the command of the current state,
// so op is in phase with state_dbg.
module noc_sim_sequencer
  import noc_sim_sequencer_pkg::*;
#(
  parameter int NUM_ROUTERS = 16,
  parameter int CYC_W       = 16,
  parameter int QUIET_W     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [CREDIT_W-1:0]    cfg_credit_dly,
  input  logic [CYC_W-1:0]       cfg_max_cycles,
  input  logic [QUIET_W-1:0]     cfg_quiet,
  noc_sim_sequencer_if.master    bus,
  input  logic                   inj_busy,
  input  logic [NUM_ROUTERS-1:0] done_vec,
  output logic                   busy,
  output logic                   finished,
  output logic                   timeout,
  output seq_state_t             state_dbg
);

  seq_state_t        state_q,    state_n;
  logic [OP_W-1:0]   op_q,       op_n;
  logic [DATA_W-1:0] data_q,     data_n;
  logic [CYC_W-1:0]  in_cycle_q, in_cycle_n;
  logic              busy_q,     busy_n;
  logic              finished_q, finished_n;
  logic              timeout_q,  timeout_n;
  logic              rt_ready_q, rt_ready_n;
  // Last routing entry accepted; its LoadRt cycle is being driven now.
  logic              rt_last_seen_q, rt_last_seen_n;

  logic rt_fire;
  logic q_sample;
  logic q_clear;
  logic quiet_reached;

  noc_seq_quiet_det #(
    .NUM_ROUTERS (NUM_ROUTERS),
    .QUIET_W     (QUIET_W)
  ) u_quiet_det (
    .clk           (clk),
    .rst_n         (rst_n),
    .done_vec      (done_vec),
    .inj_busy      (inj_busy),
    .sample        (q_sample),
    .clear         (q_clear),
    .cfg_quiet     (cfg_quiet),
    .quiet_reached (quiet_reached)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      op_q           <= OP_NOP;
      data_q         <= '0;
      in_cycle_q     <= '0;
      busy_q         <= 1'b0;
      finished_q     <= 1'b0;
      timeout_q      <= 1'b0;
      rt_ready_q     <= 1'b0;
      rt_last_seen_q <= 1'b0;
    end else begin
      state_q        <= state_n;
      op_q           <= op_n;
      data_q         <= data_n;
      in_cycle_q     <= in_cycle_n;
      busy_q         <= busy_n;
      finished_q     <= finished_n;
      timeout_q      <= timeout_n;
      rt_ready_q     <= rt_ready_n;
      rt_last_seen_q <= rt_last_seen_n;
    end
  end

  always_comb begin
    state_n        = state_q;
    op_n           = OP_NOP;
    data_n         = data_q;
    in_cycle_n     = in_cycle_q;
    busy_n         = busy_q;
    finished_n     = finished_q;
    timeout_n      = timeout_q;
    rt_ready_n     = 1'b0;
    rt_last_seen_n = rt_last_seen_q;
    q_sample       = 1'b0;
    q_clear        = 1'b0;
    rt_fire        = bus.rt_valid & rt_ready_q;

    if ((state_q != ST_IDLE) && abort) begin
      // Abort leaves finished/timeout as they were.
      state_n        = ST_IDLE;
      data_n         = '0;
      busy_n         = 1'b0;
      rt_last_seen_n = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_n    = ST_INIT;
            op_n       = OP_INIT;
            data_n     = init_data(cfg_credit_dly);
            busy_n     = 1'b1;
            finished_n = 1'b0;
            timeout_n  = 1'b0;
            in_cycle_n = '0;
            q_clear    = 1'b1;
          end
        end

        ST_INIT: begin
          state_n    = ST_LOAD_RT;
          rt_ready_n = 1'b1;
        end

        ST_LOAD_RT: begin
          if (rt_last_seen_q) begin
            // The last entry's LoadRt was driven this cycle; move on.
            state_n        = ST_LD_STG;
            op_n           = OP_LOAD_STAGING;
            data_n         = '0;
            rt_last_seen_n = 1'b0;
          end else begin
            rt_ready_n = 1'b1;
            if (rt_fire) begin
              op_n   = OP_LOAD_RT;
              data_n = bus.rt_data;
              if (bus.rt_last) begin
                rt_last_seen_n = 1'b1;
                rt_ready_n     = 1'b0;
              end
            end
          end
        end

        ST_LD_STG: begin
          state_n = ST_PH0;
          op_n    = OP_PHASE0;
          data_n  = '0;
        end

        ST_PH0: begin
          state_n = ST_PH1;
          op_n    = OP_PHASE1;
          data_n  = '0;
        end

        ST_PH1: begin
          // done_vec now reflects the Phase1 consumed at the last negedge.
          q_sample = 1'b1;
          data_n   = '0;
          if (quiet_reached) begin
            state_n    = ST_IDLE;
            finished_n = 1'b1;
            busy_n     = 1'b0;
          end else if ((cfg_max_cycles != '0) && (in_cycle_q == cfg_max_cycles)) begin
            state_n    = ST_IDLE;
            finished_n = 1'b1;
            timeout_n  = 1'b1;
            busy_n     = 1'b0;
          end else begin
            // Wraps naturally when unlimited.
            in_cycle_n = in_cycle_q + 1'b1;
            state_n    = ST_LD_STG;
            op_n       = OP_LOAD_STAGING;
          end
        end

        default: begin
          state_n = ST_IDLE;
          busy_n  = 1'b0;
        end
      endcase
    end
  end

  assign bus.op       = op_q;
  assign bus.data     = data_q;
  assign bus.in_cycle = in_cycle_q;
  assign bus.rt_ready = rt_ready_q;
  assign busy         = busy_q;
  assign finished     = finished_q;
  assign timeout      = timeout_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_noc_sim_sequencer.sv
module tb_noc_sim_sequencer;
  import noc_sim_sequencer_pkg::*;

  localparam int NR = 16;
  localparam int CW = 16;
  localparam int QW = 4;
  localparam int EW = OP_W + DATA_W + CW;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic                abort;
  logic [CREDIT_W-1:0] cfg_credit_dly;
  logic [CW-1:0]       cfg_max_cycles;
  logic [QW-1:0]       cfg_quiet;
  logic                inj_busy;
  logic [NR-1:0]       done_vec;
  logic                busy;
  logic                finished;
  logic                timeout;
  seq_state_t          state_dbg;

  noc_sim_sequencer_if #(.CYC_W(CW)) bus ();

  noc_sim_sequencer #(
    .NUM_ROUTERS (NR),
    .CYC_W       (CW),
    .QUIET_W     (QW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .cfg_credit_dly (cfg_credit_dly),
    .cfg_max_cycles (cfg_max_cycles),
    .cfg_quiet      (cfg_quiet),
    .bus            (bus),
    .inj_busy       (inj_busy),
    .done_vec       (done_vec),
    .busy           (busy),
    .finished       (finished),
    .timeout        (timeout),
    .state_dbg      (state_dbg)
  );

  int n_chk = 0;
  int n_err = 0;

  // Scoreboard: expected non-NOP commands {op, data, in_cycle} in order.
  logic [EW-1:0] exp_q[$];

  // Per-run stimulus description.
  logic [DATA_W-1:0] beats_q[$];
  logic [NR-1:0]     pd_q[$];    // done_vec per iteration
  logic              pi_q[$];    // inj_busy per iteration
  int                gap_mode;   // 0 no gaps, 1 random gaps, 2 pattern 1,0,0,1
  int                abort_iter; // iteration whose Phase0 gets aborted, -1 none
  bit                run_over;

  bit                exp_fin;
  bit                exp_to;
  logic [CW-1:0]     exp_cyc;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // ---------------- monitor ----------------
  logic [OP_W-1:0] prev_op;
  initial begin
    logic [EW-1:0] got;
    logic [EW-1:0] e;
    prev_op = OP_NOP;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_op = OP_NOP;
      end else begin
        if (bus.op != OP_NOP) begin
          got = {bus.op, bus.data, bus.in_cycle};
          if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_cmd got=%0h want=none", got);
          end else begin
            e = exp_q.pop_front();
            check("cmd_bus", 64'(got), 64'(e));
          end
        end
        case (bus.op)
          OP_INIT:         check("seq_init_after_nop", 64'(prev_op), 64'(OP_NOP));
          OP_LOAD_STAGING: check("seq_ls_after_rt_or_p1",
                                 64'((prev_op == OP_LOAD_RT) || (prev_op == OP_PHASE1)), 64'd1);
          OP_PHASE0:       check("seq_p0_after_ls", 64'(prev_op), 64'(OP_LOAD_STAGING));
          OP_PHASE1:       check("seq_p1_after_p0", 64'(prev_op), 64'(OP_PHASE0));
          default: ;
        endcase
        prev_op = bus.op;
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic build_model(input logic [CREDIT_W-1:0] credit, input int quiet,
                             input int maxc, input int ab);
    int  thr;
    int  cnt;
    bit  q;
    logic [CW-1:0] cyc;
    exp_q.push_back({OP_INIT, {20'd0, credit}, CW'(0)});
    foreach (beats_q[b]) exp_q.push_back({OP_LOAD_RT, beats_q[b], CW'(0)});
    thr = (quiet == 0) ? 1 : quiet;
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc = CW'(i);
      exp_q.push_back({OP_LOAD_STAGING, 32'd0, cyc});
      exp_q.push_back({OP_PHASE0, 32'd0, cyc});
      if (i == ab) begin
        exp_fin = 1'b0; exp_to = 1'b0; exp_cyc = cyc;
        return;
      end
      exp_q.push_back({OP_PHASE1, 32'd0, cyc});
      q = (i < pd_q.size()) ? ((&pd_q[i]) && !pi_q[i]) : 1'b0;
      cnt = q ? ((cnt < (2**QW - 1)) ? cnt + 1 : cnt) : 0;
      if (cnt >= thr) begin
        exp_fin = 1'b1; exp_to = 1'b0; exp_cyc = cyc;
        return;
      end
      if ((maxc != 0) && (i == maxc)) begin
        exp_fin = 1'b1; exp_to = 1'b1; exp_cyc = cyc;
        return;
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic rt_drive();
    int idx = 0;
    int rc = 0;
    int guard = 0;
    bit v;
    bit last_acc = 0;
    while ((idx < beats_q.size()) && !run_over && (guard < 2000)) begin
      @(negedge clk);
      guard++;
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = ($urandom_range(0, 1) == 1);
        default: begin
          v = bus.rt_ready && ((rc == 0) || (rc == 3));
          if (bus.rt_ready) rc++;
        end
      endcase
      bus.rt_valid = v;
      bus.rt_data  = v ? beats_q[idx] : $urandom();
      bus.rt_last  = (idx == beats_q.size() - 1);
      if (v && bus.rt_ready) begin
        idx++;
        if (idx == beats_q.size()) last_acc = 1'b1;
      end
    end
    if (last_acc) begin
      @(negedge clk);
      check("rt_ready_after_last", 64'(bus.rt_ready), 64'd0);
    end
    bus.rt_valid = 1'b0;
    bus.rt_last  = 1'b0;
  endtask

  task automatic q_drive();
    int k = 0;
    done_vec = '0;
    inj_busy = 1'b0;
    while (!run_over) begin
      @(negedge clk);
      abort = 1'b0;
      if (bus.op == OP_LOAD_STAGING) begin
        done_vec = (k < pd_q.size()) ? pd_q[k] : '0;
        inj_busy = (k < pi_q.size()) ? pi_q[k] : 1'b0;
        k++;
      end else if ((bus.op == OP_PHASE0) && (abort_iter >= 0) && (k - 1 == abort_iter)) begin
        abort = 1'b1;
      end
    end
    abort = 1'b0;
  endtask

  task automatic end_wait();
    int c = 0;
    while (busy && (c < 3000)) begin
      @(negedge clk);
      c++;
    end
    if (busy) begin
      n_chk++;
      n_err++;
      $display("FAIL run_end busy=1 after %0d cycles want busy=0", c);
    end
    run_over = 1'b1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_run(input string name, input logic [CREDIT_W-1:0] credit,
                        input int quiet, input int maxc);
    exp_q.delete();
    cfg_credit_dly = credit;
    cfg_quiet      = QW'(quiet);
    cfg_max_cycles = CW'(maxc);
    build_model(credit, quiet, maxc, abort_iter);
    run_over = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy_after_start"}, 64'(busy), 64'd1);
    fork
      rt_drive();
      q_drive();
      end_wait();
    join
    #1;
    check({name, "_finished"}, 64'(finished), 64'(exp_fin));
    check({name, "_timeout"}, 64'(timeout), 64'(exp_to));
    check({name, "_in_cycle"}, 64'(bus.in_cycle), 64'(exp_cyc));
    check({name, "_op_idle"}, 64'(bus.op), 64'(OP_NOP));
    check({name, "_rt_ready_idle"}, 64'(bus.rt_ready), 64'd0);
    check({name, "_state_idle"}, 64'(state_dbg), 64'(ST_IDLE));
    check({name, "_cmds_drained"}, 64'(exp_q.size()), 64'd0);
    if (busy) apply_reset();
    exp_q.delete();
  endtask

  task automatic fill_iters(input int n, input logic [NR-1:0] d, input logic inj);
    pd_q.delete();
    pi_q.delete();
    for (int i = 0; i < n; i++) begin
      pd_q.push_back(d);
      pi_q.push_back(inj);
    end
  endtask

  task automatic fill_beats(input int n);
    beats_q.delete();
    for (int i = 0; i < n; i++) beats_q.push_back($urandom());
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c;
    logic [CREDIT_W-1:0] cred;
    rst_n          = 1'b0;
    start          = 1'b0;
    abort          = 1'b0;
    cfg_credit_dly = '0;
    cfg_max_cycles = '0;
    cfg_quiet      = '0;
    inj_busy       = 1'b0;
    done_vec       = '0;
    bus.rt_valid   = 1'b0;
    bus.rt_data    = '0;
    bus.rt_last    = 1'b0;
    gap_mode       = 0;
    abort_iter     = -1;
    run_over       = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_op", 64'(bus.op), 64'(OP_NOP));
    check("rst_data", 64'(bus.data), 64'd0);
    check("rst_in_cycle", 64'(bus.in_cycle), 64'd0);
    check("rst_rt_ready", 64'(bus.rt_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_finished", 64'(finished), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    check("rst_state", 64'(state_dbg), 64'(ST_IDLE));

    // Three entries back to back, always done, quiet after 2 iterations.
    gap_mode = 0;
    fill_beats(3);
    fill_iters(4, '1, 1'b0);
    do_run("basic", 12'h3a7, 2, 0);

    // Entry gaps 1,0,0,1+last.
    gap_mode = 2;
    fill_beats(2);
    fill_iters(2, '1, 1'b0);
    do_run("gaps", 12'h011, 1, 0);

    // Never done, limit 5.
    gap_mode = 0;
    fill_beats(1);
    fill_iters(8, '0, 1'b0);
    do_run("limit", 12'hfff, 2, 5);

    // Quiet pattern 1,1,0,1,1,1 with threshold 3.
    fill_beats(2);
    pd_q = '{'1, '1, 16'h7fff, '1, '1, '1};
    pi_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    do_run("quiet3", 12'h0c3, 3, 0);

    // All done but injector busy for 4 iterations.
    fill_beats(1);
    pd_q.delete(); pi_q.delete();
    for (int i = 0; i < 8; i++) begin
      pd_q.push_back('1);
      pi_q.push_back(i < 4);
    end
    do_run("injbusy", 12'h555, 2, 0);

    // cfg_quiet of 0 behaves as 1; quiescence beats the limit on the same iteration.
    fill_beats(1);
    pd_q = '{16'h0001, '1};
    pi_q = '{1'b0, 1'b0};
    do_run("quiet0_vs_limit", 12'h123, 0, 1);

    // Randomised runs.
    gap_mode = 1;
    for (int r = 0; r < 12; r++) begin
      int maxc;
      maxc = $urandom_range(1, 12);
      fill_beats($urandom_range(1, 5));
      pd_q.delete(); pi_q.delete();
      for (int i = 0; i <= maxc; i++) begin
        logic [NR-1:0] d;
        if ($urandom_range(0, 9) < 6) d = '1;
        else begin
          d = NR'($urandom());
          d[$urandom_range(0, NR-1)] = 1'b0;
        end
        pd_q.push_back(d);
        pi_q.push_back($urandom_range(0, 9) < 2);
      end
      do_run("rand", CREDIT_W'($urandom()), $urandom_range(0, 4), maxc);
    end

    // Abort during Phase0 of simulated cycle 7.
    gap_mode = 0;
    fill_beats(2);
    fill_iters(0, '0, 1'b0);
    abort_iter = 7;
    do_run("abort", 12'h777, 1, 0);
    abort_iter = -1;

    // Reset pulse while loading the routing table.
    exp_q.delete();
    beats_q.delete();
    cred = 12'ha5c;
    cfg_credit_dly = cred;
    exp_q.push_back({OP_INIT, {20'd0, cred}, CW'(0)});
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (!bus.rt_ready && (c < 20)) begin
      @(negedge clk);
      c++;
    end
    check("pre_rst_rt_ready", 64'(bus.rt_ready), 64'd1);
    check("pre_rst_busy", 64'(busy), 64'd1);
    check("pre_rst_data", 64'(bus.data), 64'({20'd0, cred}));
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_op", 64'(bus.op), 64'(OP_NOP));
    check("midrst_data", 64'(bus.data), 64'd0);
    check("midrst_in_cycle", 64'(bus.in_cycle), 64'd0);
    check("midrst_rt_ready", 64'(bus.rt_ready), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_finished", 64'(finished), 64'd0);
    check("midrst_timeout", 64'(timeout), 64'd0);
    check("midrst_state", 64'(state_dbg), 64'(ST_IDLE));
    check("midrst_cmds_drained", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
